bootram_loader: RTL and testbench

- Writer side of the 2Kx8 single-port boot RAM; the picorv32 instruction fetch is the reader.
- Receives a framed program image as a byte stream from the UART receiver and writes it into the boot RAM through the RAM's ad/din/wre/ce port.
- Holds the CPU in reset until the image is loaded and verified, or a skip is requested.
- After release, hands the RAM port over to the CPU-side bus through a registered ownership mux.

---
 rtl/bootram_pkg.sv | 23 ++
 rtl/bootram_port_mux.sv | 48 ++++
 rtl/bootram_loader.sv | 167 ++++++++++++++++
 tb/tb_bootram_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bootram_pkg.sv
// Shared types and defaults for the boot RAM loader and its port mux.
package bootram_pkg;

  localparam int         ADDR_W_DEF    = 11;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'h55;
  localparam int         TIMEOUT_DEF   = 1000000;

  typedef enum logic [2:0] {
    IDLE,
    LEN_L,
    LEN_H,
    DATA,
    CSUM,
    ABORT,
    DONE
  } state_t;

  // True while a frame is in progress, i.e. where the inter-byte timer runs.
  function automatic logic in_frame(input state_t s);
    return (s == LEN_L) || (s == LEN_H) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/bootram_port_mux.sv
// Registered ownership mux for the boot RAM port: loader writes before
// release, a one-cycle-delayed copy of the CPU-side bus afterwards.
module bootram_port_mux #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              own_cpu,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_ad,
  input  logic [7:0]        wr_din,
  input  logic [ADDR_W-1:0] cpu_ad,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_ce,
  input  logic              cpu_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_din,
  output logic              ram_ce,
  output logic              ram_wre,
  output logic              ram_oce
);

  // Register the selected owner's request; loader address/data hold between writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_ad  <= '0;
      ram_din <= '0;
      ram_ce  <= 1'b0;
      ram_wre <= 1'b0;
      ram_oce <= 1'b0;
    end else if (own_cpu) begin
      ram_ad  <= cpu_ad;
      ram_din <= cpu_din;
      ram_ce  <= cpu_ce;
      ram_wre <= cpu_wre;
      ram_oce <= 1'b1;
    end else begin
      ram_ce  <= wr_en;
      ram_wre <= wr_en;
      ram_oce <= 1'b0;
      if (wr_en) begin
        ram_ad  <= wr_ad;
        ram_din <= wr_din;
      end
    end
  end

endmodule

// File: rtl/bootram_loader.sv
// Boot RAM loader: parses a framed image from the UART byte stream, writes
// it into the boot RAM and releases the CPU once the checksum matches.
//
//   state | meaning
//   IDLE  | waiting for sync byte or skip request
//   LEN_L | expecting low length byte
//   LEN_H | expecting high length byte, length is range-checked here
//   DATA  | each byte is written to RAM and added to the checksum
//   CSUM  | expecting checksum byte
//   ABORT | one cycle, flags load_err, back to IDLE
//   DONE  | terminal, CPU owns the RAM and leaves reset
module bootram_loader
  import bootram_pkg::*;
#(
  parameter int         ADDR_W    = ADDR_W_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              skip_load,
  input  logic [ADDR_W-1:0] cpu_ad,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_ce,
  input  logic              cpu_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_din,
  output logic              ram_ce,
  output logic              ram_wre,
  output logic              ram_oce,
  output logic              cpu_resetn,
  output logic              load_done,
  output logic              load_err
);

  localparam int          TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  state_t            state, nxt;
  logic [ADDR_W:0]   addr;
  logic [ADDR_W:0]   addr_inc;
  logic [15:0]       len;
  logic [16:0]       len_rx;
  logic [7:0]        sum;
  logic [TMR_W-1:0]  tmr;
  logic              tmo;
  logic              last_byte;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_ad;
  logic [7:0]        wr_din;

  // A byte on the terminal cycle takes priority over the timeout.
  assign tmo       = in_frame(state) && !rx_valid && (tmr == '0);
  assign len_rx    = {1'b0, rx_data, len[7:0]};
  assign addr_inc  = addr + 1'b1;
  assign last_byte = (17'(addr_inc) == {1'b0, len});

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  // Next state and loader write request.
  always_comb begin
    nxt    = state;
    wr_en  = 1'b0;
    wr_ad  = addr[ADDR_W-1:0];
    wr_din = rx_data;
    case (state)
      IDLE: begin
        if (skip_load)                           nxt = DONE;
        else if (rx_valid && rx_data == SYNC_BYTE) nxt = LEN_L;
      end
      LEN_L: begin
        if (rx_valid) nxt = LEN_H;
        else if (tmo) nxt = ABORT;
      end
      LEN_H: begin
        if (rx_valid) begin
          if (len_rx > MAX_LEN)   nxt = ABORT;
          else if (len_rx == '0)  nxt = CSUM;
          else                    nxt = DATA;
        end else if (tmo) begin
          nxt = ABORT;
        end
      end
      DATA: begin
        if (rx_valid) begin
          wr_en = 1'b1;
          if (last_byte) nxt = CSUM;
        end else if (tmo) begin
          nxt = ABORT;
        end
      end
      CSUM: begin
        if (rx_valid) nxt = (rx_data == sum) ? DONE : ABORT;
        else if (tmo) nxt = ABORT;
      end
      ABORT:   nxt = IDLE;
      DONE:    nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  // Inter-byte down-counter plus length, address and checksum capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmr  <= TMR_W'(TIMEOUT - 1);
      addr <= '0;
      len  <= '0;
      sum  <= '0;
    end else begin
      if (!in_frame(state) || rx_valid) tmr <= TMR_W'(TIMEOUT - 1);
      else if (tmr != '0)               tmr <= tmr - 1'b1;
      if (rx_valid) begin
        case (state)
          LEN_L: len[7:0] <= rx_data;
          LEN_H: begin
            len[15:8] <= rx_data;
            addr      <= '0;
            sum       <= '0;
          end
          DATA: begin
            addr <= addr_inc;
            sum  <= sum + rx_data;
          end
          default: ;
        endcase
      end
    end
  end

  // Status flags; the CPU leaves reset one cycle after load_done rises.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      cpu_resetn <= 1'b0;
    end else begin
      load_done  <= (nxt == DONE);
      load_err   <= load_err | (state == ABORT);
      cpu_resetn <= load_done;
    end
  end

  bootram_port_mux #(.ADDR_W(ADDR_W)) u_port_mux (
    .clk     (clk),
    .resetn  (resetn),
    .own_cpu (nxt == DONE),
    .wr_en   (wr_en),
    .wr_ad   (wr_ad),
    .wr_din  (wr_din),
    .cpu_ad  (cpu_ad),
    .cpu_din (cpu_din),
    .cpu_ce  (cpu_ce),
    .cpu_wre (cpu_wre),
    .ram_ad  (ram_ad),
    .ram_din (ram_din),
    .ram_ce  (ram_ce),
    .ram_wre (ram_wre),
    .ram_oce (ram_oce)
  );

endmodule

// File: tb/tb_bootram_loader.sv
// Self-checking bench for bootram_loader: directed frames plus randomized
// frames checked against a byte-list level model of the frame protocol.
module tb_bootram_loader;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int TMO    = 40;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              skip_load = 1'b0;
  logic [ADDR_W-1:0] cpu_ad = '0;
  logic [7:0]        cpu_din = '0;
  logic              cpu_ce = 1'b0;
  logic              cpu_wre = 1'b0;
  logic [ADDR_W-1:0] ram_ad;
  logic [7:0]        ram_din;
  logic              ram_ce, ram_wre, ram_oce;
  logic              cpu_resetn, load_done, load_err;

  always #5 clk = ~clk;

  bootram_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'h55), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .skip_load(skip_load), .cpu_ad(cpu_ad), .cpu_din(cpu_din),
    .cpu_ce(cpu_ce), .cpu_wre(cpu_wre), .ram_ad(ram_ad), .ram_din(ram_din),
    .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_oce(ram_oce),
    .cpu_resetn(cpu_resetn), .load_done(load_done), .load_err(load_err)
  );

  int n_chk = 0;
  int n_err = 0;

  // Behavioural boot RAM: records every write cycle seen on the port.
  logic [7:0] mem     [DEPTH];
  logic [7:0] exp_mem [DEPTH];
  int wr_cnt = 0;
  int last_wr_ad = -1;
  always @(negedge clk) begin
    if (ram_ce && ram_wre) begin
      mem[ram_ad] = ram_din;
      wr_cnt++;
      last_wr_ad = int'(ram_ad);
    end
  end

  logic [7:0] fq[$];
  int         gq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic run_frame();
    for (int i = 0; i < fq.size(); i++) send_byte(fq[i], gq[i]);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(1);
  endtask

  // Frame-level reference: byte list and gaps in, outcome and RAM image out.
  task automatic predict(output bit ok, output int nw);
    int len, need, cut, sum;
    ok   = 1'b0;
    nw   = 0;
    len  = int'(fq[1]) + 256 * int'(fq[2]);
    need = (len > DEPTH) ? 3 : len + 4;
    cut  = need;
    for (int i = 0; i < need - 1 && i < fq.size(); i++) begin
      if (gq[i] >= TMO) begin
        cut = i + 1;
        break;
      end
    end
    if (len > DEPTH) return;
    nw = (cut >= need) ? len : ((cut > 3) ? cut - 3 : 0);
    for (int k = 0; k < nw; k++) exp_mem[k] = fq[3 + k];
    if (cut < need) return;
    sum = 0;
    for (int k = 0; k < len; k++) sum += int'(fq[3 + k]);
    ok = (fq[3 + len] == 8'(sum));
  endtask

  task automatic ram_cmp(input string tag, input int nw);
    int bad = 0;
    for (int k = 0; k < nw; k++) if (mem[k] !== exp_mem[k]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  // Builds a well-formed frame of the given length with random payload.
  task automatic build_frame(input int len);
    int sum = 0;
    logic [7:0] b;
    fq = {8'h55, 8'(len), 8'(len >> 8)};
    gq = {0, 0, 0};
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      sum += int'(b);
      fq.push_back(b);
      gq.push_back(0);
    end
    fq.push_back(8'(sum));
    gq.push_back(3);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int nw, base, len, cut_i, r;
    logic [7:0] p1 [4];
    logic [7:0] j;
    p1 = '{8'h13, 8'h00, 8'h00, 8'h00};

    // Reset values while held in reset.
    resetn = 1'b0;
    tick(2);
    chk("rst_outs", 32'({ram_ad, ram_din, ram_ce, ram_wre, ram_oce,
                         cpu_resetn, load_done, load_err}), 32'd0);
    resetn = 1'b1;
    tick(1);

    // Directed frame 55 04 00 13 00 00 00 13, one-cycle write pulses.
    base = wr_cnt;
    send_byte(8'h55, 0);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++) begin
      send_byte(p1[k], 0);
      chk("f1_wre_on", 32'(ram_wre), 32'd1);
      chk("f1_wr_ad", 32'(ram_ad), 32'(k));
      chk("f1_wr_din", 32'(ram_din), 32'(p1[k]));
      tick(1);
      chk("f1_wre_off", 32'(ram_wre), 32'd0);
    end
    send_byte(8'h13, 0);
    chk("f1_done", 32'(load_done), 32'd1);
    chk("f1_cpu_rst_hold", 32'(cpu_resetn), 32'd0);
    tick(1);
    chk("f1_cpu_rst_rel", 32'(cpu_resetn), 32'd1);
    chk("f1_err", 32'(load_err), 32'd0);
    chk("f1_wr_cnt", 32'(wr_cnt - base), 32'd4);

    // Bad checksum, then a good frame: load_err stays set.
    do_reset();
    fq = {8'h55, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
    gq = {0, 0, 0, 0, 0, 0, 0, 3};
    run_frame();
    chk("bad_cs_err", 32'(load_err), 32'd1);
    chk("bad_cs_done", 32'(load_done), 32'd0);
    chk("bad_cs_cpu", 32'(cpu_resetn), 32'd0);
    fq = {8'h55, 8'h01, 8'h00, 8'h7E, 8'h7E};
    gq = {0, 0, 0, 0, 3};
    run_frame();
    chk("retry_done", 32'(load_done), 32'd1);
    chk("retry_err_sticky", 32'(load_err), 32'd1);

    // Oversize length aborts without writing.
    do_reset();
    base = wr_cnt;
    fq = {8'h55, 8'h01, 8'h08};
    gq = {0, 0, 3};
    run_frame();
    chk("len801_err", 32'(load_err), 32'd1);
    chk("len801_nowr", 32'(wr_cnt - base), 32'd0);

    // Full-depth image.
    do_reset();
    base = wr_cnt;
    build_frame(DEPTH);
    predict(ok, nw);
    run_frame();
    chk("full_done", 32'(load_done), 32'(ok));
    chk("full_wr_cnt", 32'(wr_cnt - base), 32'(nw));
    chk("full_last_ad", 32'(last_wr_ad), 32'h7FF);
    ram_cmp("full_ram", nw);

    // Timeout after one payload byte, then a byte at the last legal cycle.
    do_reset();
    fq = {8'h55, 8'h02, 8'h00, 8'hAA};
    gq = {0, 0, 0, TMO + 2};
    run_frame();
    chk("tmo_err", 32'(load_err), 32'd1);
    chk("tmo_done", 32'(load_done), 32'd0);
    do_reset();
    fq = {8'h55, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'h65};
    gq = {0, 0, 0, TMO - 1, 0, 3};
    run_frame();
    chk("tmo_edge_err", 32'(load_err), 32'd0);
    chk("tmo_edge_done", 32'(load_done), 32'd1);

    // Skip from IDLE, then CPU ownership with one cycle of latency.
    do_reset();
    cpu_ad  = 11'h123;
    cpu_din = 8'h5A;
    cpu_ce  = 1'b1;
    skip_load = 1'b1;
    tick(1);
    skip_load = 1'b0;
    chk("skip_done", 32'(load_done), 32'd1);
    chk("skip_oce", 32'(ram_oce), 32'd1);
    chk("skip_ad", 32'(ram_ad), 32'h123);
    chk("skip_ce", 32'(ram_ce), 32'd1);
    chk("skip_cpu_hold", 32'(cpu_resetn), 32'd0);
    tick(1);
    chk("skip_cpu_rel", 32'(cpu_resetn), 32'd1);
    cpu_ad = 11'h2AA;
    #1;
    chk("cpu_ad_latency", 32'(ram_ad), 32'h123);
    tick(1);
    chk("cpu_ad_follow", 32'(ram_ad), 32'h2AA);
    send_byte(8'h55, 2);
    chk("done_ignores_rx", 32'(load_done), 32'd1);
    cpu_ce = 1'b0;
    cpu_ad = '0;
    cpu_din = '0;

    // Sync and skip together: skip wins.
    do_reset();
    rx_data = 8'h55; rx_valid = 1'b1; skip_load = 1'b1;
    tick(1);
    rx_valid = 1'b0; skip_load = 1'b0;
    chk("sync_skip_done", 32'(load_done), 32'd1);

    // Skip mid-frame is ignored.
    do_reset();
    fq = {8'h55, 8'h03, 8'h00, 8'h11};
    gq = {0, 0, 0, 0};
    run_frame();
    skip_load = 1'b1;
    tick(1);
    skip_load = 1'b0;
    chk("skip_in_data", 32'(load_done), 32'd0);
    fq = {8'h22, 8'h33, 8'h66};
    gq = {0, 0, 3};
    run_frame();
    chk("skip_in_data_fin", 32'(load_done), 32'd1);

    // Asynchronous reset mid-payload, then a fresh load from address 0.
    do_reset();
    fq = {8'h55, 8'h04, 8'h00, 8'hA1, 8'hA2};
    gq = {0, 0, 0, 0, 0};
    run_frame();
    chk("midrst_pre_wre", 32'(ram_wre), 32'd1);
    resetn = 1'b0;
    #1;
    chk("midrst_outs", 32'({ram_ad, ram_din, ram_ce, ram_wre, ram_oce,
                           cpu_resetn, load_done, load_err}), 32'd0);
    tick(2);
    resetn = 1'b1;
    tick(1);
    fq = {8'h55, 8'h02, 8'h00, 8'hC1, 8'hC2, 8'h83};
    gq = {0, 0, 0, 0, 0, 3};
    run_frame();
    chk("fresh_mem0", 32'(mem[0]), 32'hC1);
    chk("fresh_mem1", 32'(mem[1]), 32'hC2);
    chk("fresh_done", 32'(load_done), 32'd1);

    // Randomized frames against the frame-level model.
    for (int it = 0; it < 16; it++) begin
      do_reset();
      repeat ($urandom_range(0, 2)) begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'h55) j = 8'h54;
        send_byte(j, $urandom_range(0, 2));
      end
      len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
      build_frame(len);
      if ($urandom_range(0, 2) == 0) fq[fq.size() - 1] ^= 8'($urandom_range(1, 255));
      for (int i = 0; i < gq.size() - 1; i++) begin
        r = $urandom_range(0, 9);
        gq[i] = (r == 0) ? TMO - 1 : ((r < 3) ? $urandom_range(1, 3) : 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        cut_i = $urandom_range(2, fq.size() - 2);
        while (fq.size() > cut_i + 1) begin
          fq.delete(fq.size() - 1);
          gq.delete(gq.size() - 1);
        end
        gq[cut_i] = TMO + 2 + $urandom_range(0, 5);
      end
      base = wr_cnt;
      predict(ok, nw);
      run_frame();
      chk("rnd_done", 32'(load_done), 32'(ok));
      chk("rnd_err", 32'(load_err), 32'(!ok));
      chk("rnd_cpu_rst", 32'(cpu_resetn), 32'(ok));
      chk("rnd_wr_cnt", 32'(wr_cnt - base), 32'(nw));
      ram_cmp("rnd_ram", nw);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
